myc64_prg_loader: RTL

//  Streams a .PRG image from a host byte source (SPI/UART bridge) into C64 main RAM.
//  All RAM writes go through the external ph2 write port of myc64_top (i_ext_*/o_ext_ready).

---
 rtl/myc64_pkg.sv | 20 ++
 rtl/myc64_sync_fifo.sv | 53 +++++
 rtl/myc64_prg_loader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/myc64_pkg.sv
// Shared types and constants for the C64 .PRG loader slice.
package myc64_pkg;

    localparam int EXT_DW = 8;
    localparam int EXT_AW = 16;

    localparam logic [EXT_AW-1:0] DEFAULT_PTR_ADDR = 16'h002D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_LO,
        ST_HDR_HI,
        ST_DATA,
        ST_PATCH_LO,
        ST_PATCH_HI,
        ST_DONE,
        ST_ERR
    } ldr_state_t;

endpackage

// File: rtl/myc64_sync_fifo.sv
// Single-clock FIFO with registered read data; holds DEPTH entries when full.
module myc64_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit tells a full FIFO apart from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_data <= '0;
        end else if (do_pop) begin
            pop_data <= mem[rd_ptr[AW-1:0]];
        end
    end

endmodule

// File: rtl/myc64_prg_loader.sv
// Streams a .PRG image from a host byte source into C64 RAM through the ext write port.
//
// state    | meaning
// IDLE     | waiting for i_start
// HDR_LO   | capturing load address low byte
// HDR_HI   | capturing load address high byte
// DATA     | buffering payload and writing it one byte per ext cycle
// PATCH_LO | writing end address low byte to PTR_ADDR
// PATCH_HI | writing end address high byte to PTR_ADDR+1
// DONE     | one-cycle completion pulse
// ERR      | flagging error and draining host bytes through i_s_last
module myc64_prg_loader
    import myc64_pkg::*;
#(
    parameter int                FIFO_DEPTH = 16,
    parameter bit                PATCH_EN   = 1'b1,
    parameter logic [EXT_AW-1:0] PTR_ADDR   = DEFAULT_PTR_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_s_valid,
    input  logic [EXT_DW-1:0] i_s_data,
    input  logic              i_s_last,
    output logic              o_s_ready,
    output logic              o_ext_we,
    output logic [EXT_AW-1:0] o_ext_addr,
    output logic [EXT_DW-1:0] o_ext_data,
    input  logic              i_ext_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [EXT_AW-1:0] o_end_addr
);

    ldr_state_t        state, n_state;
    logic              ext_we, n_ext_we;
    logic [EXT_AW-1:0] ext_addr, n_ext_addr;
    logic [EXT_DW-1:0] ext_data, n_ext_data;
    logic [EXT_AW-1:0] end_addr, n_end_addr;
    logic              last_seen, n_last_seen;
    logic              staged, n_staged;
    logic              wrapped, n_wrapped;
    logic              error_q, n_error;

    logic              fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
    logic [EXT_DW-1:0] fifo_rd_data;
    logic              host_hs, ack, commit, wrap_now, load;
    logic [EXT_AW-1:0] ptr_next;

    myc64_sync_fifo #(.DW(EXT_DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (fifo_clr),
        .push      (fifo_push),
        .push_data (i_s_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        o_s_ready = 1'b0;
        case (state)
            ST_HDR_LO, ST_HDR_HI: o_s_ready = 1'b1;
            ST_DATA:              o_s_ready = !fifo_full && !last_seen;
            ST_ERR:               o_s_ready = !last_seen;
            default:              o_s_ready = 1'b0;
        endcase
    end

    assign host_hs    = i_s_valid && o_s_ready;
    assign ack        = i_ext_ready && ext_we;
    assign o_ext_we   = ext_we;
    assign o_ext_addr = ext_addr;
    assign o_ext_data = ext_data;
    assign o_end_addr = end_addr;
    assign o_error    = error_q;
    assign o_done     = (state == ST_DONE);
    assign o_busy     = (state == ST_HDR_LO) || (state == ST_HDR_HI) || (state == ST_DATA) ||
                        (state == ST_PATCH_LO) || (state == ST_PATCH_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_data  <= '0;
            end_addr  <= '0;
            last_seen <= 1'b0;
            staged    <= 1'b0;
            wrapped   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state     <= n_state;
            ext_we    <= n_ext_we;
            ext_addr  <= n_ext_addr;
            ext_data  <= n_ext_data;
            end_addr  <= n_end_addr;
            last_seen <= n_last_seen;
            staged    <= n_staged;
            wrapped   <= n_wrapped;
            error_q   <= n_error;
        end
    end

    // The FIFO read register acts as a one-byte prefetch stage ("staged"), so the
    // next byte is ready to present on the very cycle a write is acknowledged.
    always_comb begin
        n_state     = state;
        n_ext_we    = ext_we;
        n_ext_addr  = ext_addr;
        n_ext_data  = ext_data;
        n_end_addr  = end_addr;
        n_last_seen = last_seen;
        n_staged    = staged;
        n_wrapped   = wrapped;
        n_error     = error_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        fifo_clr    = 1'b0;
        commit      = 1'b0;
        wrap_now    = wrapped;
        load        = 1'b0;
        ptr_next    = end_addr;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    n_state     = ST_HDR_LO;
                    n_error     = 1'b0;
                    n_last_seen = 1'b0;
                    n_staged    = 1'b0;
                    n_wrapped   = 1'b0;
                    fifo_clr    = 1'b1;
                end
            end
            ST_HDR_LO: begin
                if (host_hs) begin
                    n_end_addr[7:0] = i_s_data;
                    if (i_s_last) begin
                        n_state     = ST_ERR;
                        n_error     = 1'b1;
                        n_last_seen = 1'b1;
                    end else begin
                        n_state = ST_HDR_HI;
                    end
                end
            end
            ST_HDR_HI: begin
                if (host_hs) begin
                    n_end_addr[15:8] = i_s_data;
                    if (!i_s_last) begin
                        n_state = ST_DATA;
                    end else if (PATCH_EN) begin
                        n_state    = ST_PATCH_LO;
                        n_ext_we   = 1'b1;
                        n_ext_addr = PTR_ADDR;
                        n_ext_data = end_addr[7:0];
                    end else begin
                        n_state = ST_DONE;
                    end
                end
            end
            ST_DATA: begin
                fifo_push = host_hs;
                if (host_hs && i_s_last) n_last_seen = 1'b1;
                commit = ack;
                if (commit) begin
                    ptr_next   = end_addr + 16'd1;
                    n_end_addr = ptr_next;
                    if (end_addr == 16'hFFFF) wrap_now = 1'b1;
                end
                n_wrapped = wrap_now;
                load      = staged && (!ext_we || commit);
                if (load && wrap_now) begin
                    n_state  = ST_ERR;
                    n_ext_we = 1'b0;
                    n_error  = 1'b1;
                    n_staged = 1'b0;
                    fifo_clr = 1'b1;
                end else begin
                    if (load) begin
                        n_ext_we   = 1'b1;
                        n_ext_addr = ptr_next;
                        n_ext_data = fifo_rd_data;
                    end else if (commit) begin
                        n_ext_we = 1'b0;
                    end
                    fifo_pop = !fifo_empty && (!staged || load);
                    n_staged = fifo_pop || (staged && !load);
                    if (last_seen && fifo_empty && !staged && !ext_we) begin
                        if (PATCH_EN) begin
                            n_state    = ST_PATCH_LO;
                            n_ext_we   = 1'b1;
                            n_ext_addr = PTR_ADDR;
                            n_ext_data = end_addr[7:0];
                        end else begin
                            n_state = ST_DONE;
                        end
                    end
                end
            end
            ST_PATCH_LO: begin
                if (ack) begin
                    n_state    = ST_PATCH_HI;
                    n_ext_addr = PTR_ADDR + 16'd1;
                    n_ext_data = end_addr[15:8];
                end
            end
            ST_PATCH_HI: begin
                if (ack) begin
                    n_state  = ST_DONE;
                    n_ext_we = 1'b0;
                end
            end
            ST_DONE: n_state = ST_IDLE;
            ST_ERR: begin
                if (ack) n_ext_we = 1'b0;
                if (host_hs && i_s_last) n_last_seen = 1'b1;
                if ((last_seen || (host_hs && i_s_last)) && (!ext_we || ack)) n_state = ST_IDLE;
            end
            default: n_state = ST_IDLE;
        endcase
    end

endmodule
